// File: rtl/regbank_access_ctrl.sv
`timescale 1ns/1ps
// Register-bank initiator: operand fetch (rd_ack two cycles after rd_req is taken in IDLE), writeback FIFO drain.
// Reads beat drain; writeback producers stall on wb_ready while the FIFO is full; buffered results forward to reads.
module regbank_access_ctrl #(
   parameter int WB_DEPTH = 4,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_rs,
   input  logic [ADDR_W-1:0] rd_rt,
   output logic              rd_ack,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ready,
   output logic [ADDR_W-1:0] bank_address,
   output logic [ADDR_W-1:0] bank_addressB,
   output logic              bank_enable_read,
   output logic              bank_enable_write,
   output logic [DATA_W-1:0] bank_in_data,
   input  logic [DATA_W-1:0] bank_out_data,
   input  logic [DATA_W-1:0] bank_out_dataB
);

   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAP, WR} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] fifo_rd  [WB_DEPTH];
   logic [DATA_W-1:0] fifo_dat [WB_DEPTH];
   logic [PTR_W-1:0]  head, tail, scan_idx;
   logic [CNT_W-1:0]  count, count_nxt;
   logic              push, pop;
   logic [DATA_W-1:0] op_a_q, op_b_q, res_a, res_b;

   // Writes to r0 are acknowledged to the producer but never stored.
   assign push      = wb_valid & wb_ready & (wb_rd != '0);
   assign pop       = (state == WR);
   assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (rd_req) begin
               state_nxt = RD_ISSUE;
            end else if (count != '0) begin
               state_nxt = WR;
            end
         end
         RD_ISSUE: state_nxt = RD_CAP;
         RD_CAP:   state_nxt = IDLE;
         WR:       state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Scan oldest to youngest so the last match wins; a same-cycle push is younger than any entry.
   always_comb begin
      res_a    = bank_out_data;
      res_b    = bank_out_dataB;
      scan_idx = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         scan_idx = head + PTR_W'(i);
         if (CNT_W'(i) < count) begin
            if (fifo_rd[scan_idx] == rd_rs) res_a = fifo_dat[scan_idx];
            if (fifo_rd[scan_idx] == rd_rt) res_b = fifo_dat[scan_idx];
         end
      end
      if (push && (wb_rd == rd_rs)) res_a = wb_data;
      if (push && (wb_rd == rd_rt)) res_b = wb_data;
      if (rd_rs == '0) res_a = '0;
      if (rd_rt == '0) res_b = '0;
   end

   always_comb begin
      rd_ack            = 1'b0;
      op_a              = op_a_q;
      op_b              = op_b_q;
      bank_address      = '0;
      bank_addressB     = '0;
      bank_enable_read  = 1'b0;
      bank_enable_write = 1'b0;
      bank_in_data      = '0;
      case (state)
         RD_ISSUE: begin
            bank_address     = rd_rs;
            bank_addressB    = rd_rt;
            bank_enable_read = 1'b1;
         end
         RD_CAP: begin
            rd_ack = 1'b1;
            op_a   = res_a;
            op_b   = res_b;
         end
         WR: begin
            bank_address      = fifo_rd[head];
            bank_in_data      = fifo_dat[head];
            bank_enable_write = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         wb_ready <= 1'b1;
         op_a_q   <= '0;
         op_b_q   <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         count    <= count_nxt;
         wb_ready <= (count_nxt < CNT_W'(WB_DEPTH));
         if (state == RD_CAP) begin
            op_a_q <= res_a;
            op_b_q <= res_b;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_rd[tail]  <= wb_rd;
         fifo_dat[tail] <= wb_data;
      end
   end

endmodule

// File: tb/tb_regbank_access_ctrl.sv
`timescale 1ns/1ps
// Scoreboarded bench for regbank_access_ctrl with a behavioural register bank.
module tb_regbank_access_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct packed {logic [AW-1:0] rd; logic [DW-1:0] d;} wr_t;
   typedef struct packed {logic [DW-1:0] a; logic [DW-1:0] b;} rdx_t;

   logic          clock, reset;
   logic          rd_req, rd_ack, wb_valid, wb_ready;
   logic [AW-1:0] rd_rs, rd_rt, wb_rd, bank_address, bank_addressB;
   logic [DW-1:0] op_a, op_b, wb_data, bank_in_data, bank_out_data, bank_out_dataB;
   logic          bank_enable_read, bank_enable_write;

   logic [DW-1:0] mem     [32];
   logic [DW-1:0] ref_mem [32];
   wr_t  wq[$];
   rdx_t rq[$];
   int total = 0, bad = 0;
   int cyc = 0, req_cyc = 0, ack_cyc = 0, rd_en_cnt = 0, acks = 0, wr_cnt = 0, wr_at_ack = 0;
   int a0, w0;

   regbank_access_ctrl #(.WB_DEPTH(4), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset),
      .rd_req(rd_req), .rd_rs(rd_rs), .rd_rt(rd_rt), .rd_ack(rd_ack), .op_a(op_a), .op_b(op_b),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
      .bank_address(bank_address), .bank_addressB(bank_addressB),
      .bank_enable_read(bank_enable_read), .bank_enable_write(bank_enable_write),
      .bank_in_data(bank_in_data), .bank_out_data(bank_out_data), .bank_out_dataB(bank_out_dataB)
   );

   function automatic logic [DW-1:0] init_val(input int i);
      case (i)
         0:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0011;
         4:       return 32'h0000_0022;
         default: return 32'hA500_0000 | i;
      endcase
   endfunction

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Behavioural registers_bank: registered read, write commits on the enabled edge.
   initial begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      bank_out_data  <= '0;
      bank_out_dataB <= '0;
      forever begin
         @(posedge clock);
         if (bank_enable_write) mem[bank_address] <= bank_in_data;
         if (bank_enable_read) begin
            bank_out_data  <= mem[bank_address];
            bank_out_dataB <= mem[bank_addressB];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Architectural value: youngest pending write, else what the bank should hold.
   function automatic logic [DW-1:0] exp_val(input logic [AW-1:0] r);
      logic [DW-1:0] v;
      if (r == '0) return '0;
      v = ref_mem[r];
      foreach (wq[i]) if (wq[i].rd == r) v = wq[i].d;
      return v;
   endfunction

   task automatic monitor();
      wr_t  w;
      rdx_t x;
      if (bank_enable_read) rd_en_cnt++;
      chk("en_excl", 64'(bank_enable_read & bank_enable_write), 0);
      if (!bank_enable_read && !bank_enable_write)
         chk("bank_idle", {bank_address, bank_addressB, bank_in_data}, 0);
      if (bank_enable_write) begin
         wr_cnt++;
         chk("wr_expected", 64'(wq.size() != 0), 1);
         if (wq.size() != 0) begin
            w = wq.pop_front();
            chk("wr_addr", bank_address, w.rd);
            chk("wr_data", bank_in_data, w.d);
            ref_mem[w.rd] = w.d;
         end
      end
      if (rd_ack) begin
         acks++;
         ack_cyc   = cyc;
         wr_at_ack = wr_cnt;
         chk("ack_expected", 64'(rq.size() != 0), 1);
         if (rq.size() != 0) begin
            x = rq.pop_front();
            chk("op_a", op_a, x.a);
            chk("op_b", op_b, x.b);
         end
      end
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         monitor();
         @(posedge clock);
         cyc++;
         #1;
         if (rq.size() == 0) rd_req = 1'b0;
      end
   endtask

   task automatic push(input logic [AW-1:0] r, input logic [DW-1:0] d);
      wr_t w;
      wb_valid = 1'b1;
      wb_rd    = r;
      wb_data  = d;
      for (int i = 0; i < 50 && !wb_ready; i++) step(1);
      if (!wb_ready) begin
         chk("push_timeout", wb_ready, 1);
         wb_valid = 1'b0;
         return;
      end
      if (r != '0) begin
         w.rd = r;
         w.d  = d;
         wq.push_back(w);
      end
      step(1);
      wb_valid = 1'b0;
   endtask

   task automatic start_read(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
      rdx_t x;
      rd_rs     = rs;
      rd_rt     = rt;
      rd_req    = 1'b1;
      x.a       = exp_val(rs);
      x.b       = exp_val(rt);
      rq.push_back(x);
      req_cyc   = cyc;
      rd_en_cnt = 0;
   endtask

   task automatic wait_read();
      for (int i = 0; i < 60 && rq.size() != 0; i++) step(1);
      chk("rd_done", rq.size(), 0);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && wq.size() != 0; i++) step(1);
      chk("drain_done", wq.size(), 0);
      step(2);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
      reset = 1'b1; rd_req = 1'b0; rd_rs = '0; rd_rt = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      #2 reset = 1'b0;
      step(3);
      chk("rst_ack", rd_ack, 0);
      chk("rst_ops", {op_a, op_b}, 0);
      chk("rst_wb_ready", wb_ready, 1);
      chk("rst_bank_en", {bank_enable_read, bank_enable_write}, 0);
      reset = 1'b1;
      step(2);

      // Plain read: latency, single read-enable pulse, single ack pulse
      a0 = acks;
      start_read(5'd3, 5'd4);
      wait_read();
      chk("rd_latency", ack_cyc - req_cyc, 2);
      chk("rd_en_pulses", rd_en_cnt, 1);
      step(3);
      chk("ack_pulses", acks - a0, 1);

      // Single writeback drains to the bank, then reads back from the bank
      push(5'd5, 32'hDEAD_BEEF);
      wait_drain();
      start_read(5'd5, 5'd3);
      wait_read();

      // Youngest forwarded, r0 forced to zero despite bank contents
      push(5'd7, 32'h0000_000A);
      push(5'd7, 32'h0000_000B);
      start_read(5'd7, 5'd0);
      wait_read();
      wait_drain();

      // Fill the FIFO under a read; read first, then a read still beats the full FIFO's drain
      a0 = acks;
      w0 = wr_cnt;
      start_read(5'd3, 5'd4);
      push(5'd8,  32'h0808_0808);
      push(5'd9,  32'h0909_0909);
      push(5'd10, 32'h1010_1010);
      push(5'd11, 32'h1111_1111);
      chk("full_wb_ready", wb_ready, 0);
      chk("rd_before_drain", acks - a0, 1);
      chk("no_wr_before_rd", wr_cnt - w0, 0);
      start_read(5'd8, 5'd11);
      step(1);
      chk("ready_after_pop", wb_ready, 1);
      wait_read();
      chk("rd_prio_full", wr_at_ack - w0, 1);
      wait_drain();
      chk("drain_count", wr_cnt - w0, 4);

      // r0 writebacks are accepted but never counted or written
      w0 = wr_cnt;
      for (int i = 0; i < 4; i++) push(5'd0, 32'h0000_1234);
      chk("r0_wb_ready", wb_ready, 1);
      step(8);
      chk("r0_no_write", wr_cnt - w0, 0);
      start_read(5'd0, 5'd5);
      wait_read();

      // Reset during RD_ISSUE with two entries buffered
      push(5'd12, 32'h0000_0055);
      start_read(5'd12, 5'd13);
      push(5'd13, 32'h0000_0066);
      reset  = 1'b0;
      rd_req = 1'b0;
      wq.delete();
      rq.delete();
      #1;
      chk("mid_rst_ack", rd_ack, 0);
      chk("mid_rst_wb_ready", wb_ready, 1);
      chk("mid_rst_bank", {bank_enable_read, bank_enable_write, bank_address, bank_addressB, bank_in_data}, 0);
      step(2);
      reset = 1'b1;
      a0 = acks;
      w0 = wr_cnt;
      step(20);
      chk("post_rst_acks", acks - a0, 0);
      chk("post_rst_writes", wr_cnt - w0, 0);
      chk("post_rst_wb_ready", wb_ready, 1);
      start_read(5'd12, 5'd13);
      wait_read();

      chk("end_wq", wq.size(), 0);
      chk("end_rq", rq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
